// File: rtl/mmio_out_port.sv
// Memory-mapped output port: channel registers, status snapshot
// and a FIFO-buffered output stream with overflow interrupt.
module mmio_out_port #(
    parameter int                 DATA_W     = 64,
    parameter int                 ADDR_W     = 12,
    parameter logic [ADDR_W-1:0]  BASE_ADDR  = 12'h7F0,
    parameter int                 N_CH       = 4,
    parameter int                 FIFO_DEPTH = 8,
    parameter logic [DATA_W-1:0]  CH_RST     = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_W-1:0]      bus_addr,
    input  logic [DATA_W-1:0]      bus_wdata,
    input  logic                   bus_we,
    input  logic                   bus_re,
    output logic                   bus_hit,
    output logic [DATA_W-1:0]      bus_rdata,
    input  logic [3:0]             status_in,
    output logic [N_CH*DATA_W-1:0] ch_out,
    output logic [DATA_W-1:0]      stream_data,
    output logic                   stream_valid,
    input  logic                   stream_ready,
    output logic                   irq
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] OFF_PUSH = ADDR_W'(N_CH);
    localparam logic [ADDR_W-1:0] OFF_STAT = ADDR_W'(N_CH + 1);
    localparam logic [ADDR_W-1:0] OFF_SNAP = ADDR_W'(N_CH + 2);
    localparam logic [ADDR_W-1:0] WIN      = ADDR_W'(N_CH + 3);

    logic [DATA_W-1:0] ch_q [N_CH];
    logic [DATA_W-1:0] ch_d [N_CH];
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;
    logic [3:0]        snap_q, snap_d;
    logic              snap_valid_q, snap_valid_d;

    logic [ADDR_W-1:0] off;
    logic              wr, empty, full, pop;
    logic              push_req, push_ok, ovf_set;
    logic [DATA_W-1:0] stat;

    assign off     = bus_addr - BASE_ADDR;
    assign bus_hit = (bus_addr >= BASE_ADDR) && (off < WIN);
    assign wr      = bus_we & bus_hit;

    assign empty        = (count_q == '0);
    assign full         = (count_q == CNT_W'(FIFO_DEPTH));
    assign stream_valid = ~empty;
    assign stream_data  = empty ? '0 : mem_q[rd_ptr_q];
    assign pop          = stream_valid & stream_ready;
    assign irq          = ovf_q;

    // A full FIFO still takes a push when the head leaves the same cycle.
    assign push_req = wr & (off == OFF_PUSH);
    assign push_ok  = push_req & (~full | pop);
    assign ovf_set  = push_req & full & ~pop;

    always_comb begin
        stat = '0;
        stat[CNT_W-1:0] = count_q;
        stat[CNT_W]     = empty;
        stat[CNT_W+1]   = full;
        stat[CNT_W+2]   = ovf_q;
        stat[CNT_W+3]   = snap_valid_q;
    end

    always_comb begin
        bus_rdata = '0;
        if (bus_hit && bus_re) begin
            for (int k = 0; k < N_CH; k++) begin
                if (off == ADDR_W'(k)) bus_rdata = ch_q[k];
            end
            if (off == OFF_PUSH) bus_rdata = stream_data;
            if (off == OFF_STAT) bus_rdata = stat;
            if (off == OFF_SNAP) bus_rdata = {{(DATA_W-4){1'b0}}, snap_q};
        end
    end

    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            ch_d[k] = ch_q[k];
            if (wr && off == ADDR_W'(k)) ch_d[k] = bus_wdata;
        end
        wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop) count_d = count_q + CNT_W'(1);
        if (!push_ok && pop) count_d = count_q - CNT_W'(1);
        // A fresh overflow outranks a same-cycle clear.
        ovf_d = ovf_q;
        if (wr && off == OFF_STAT && bus_wdata[0]) ovf_d = 1'b0;
        if (ovf_set) ovf_d = 1'b1;
        snap_d       = snap_q;
        snap_valid_d = snap_valid_q;
        if (bus_hit && bus_re && off == OFF_SNAP) snap_valid_d = 1'b0;
        if (wr && off == OFF_SNAP) begin
            snap_d       = status_in;
            snap_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N_CH; k++) ch_q[k] <= CH_RST;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            ovf_q        <= 1'b0;
            snap_q       <= '0;
            snap_valid_q <= 1'b0;
        end else begin
            for (int k = 0; k < N_CH; k++) ch_q[k] <= ch_d[k];
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            ovf_q        <= ovf_d;
            snap_q       <= snap_d;
            snap_valid_q <= snap_valid_d;
        end
    end

    // Storage needs no reset: it is only observed while count is non-zero.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= bus_wdata;
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        assign ch_out[k*DATA_W +: DATA_W] = ch_q[k];
    end

endmodule
